// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad code sender:
//   - state_t     : controller states (7 states, 3-bit encoding)
//   - DIGIT_W     : width of one keypad hex digit
//   - timer_width : counter width needed to hold a given timer load value
package keypad_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ENTRY     = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_GRANTED   = 3'd4,
    ST_DENIED    = 3'd5,
    ST_LOCKOUT   = 3'd6
  } state_t;

  // Bits needed to represent 0..max_load inclusive (never less than 1).
  function automatic int timer_width(input int max_load);
    return (max_load < 1) ? 1 : $clog2(max_load + 1);
  endfunction

endpackage

// File: rtl/kp_timer.sv
// kp_timer
// Loadable down-counter. Loading value N makes o_done pulse for one cycle
// exactly N cycles later (the cycle in which the count sits at 1), so the
// owner can leave its state on the following edge after N cycles.
// A load in the same cycle as expiry restarts the count and suppresses done.
// Ports:
//   clk        in  clock, rising edge
//   reset      in  asynchronous active-high reset
//   i_load     in  load strobe
//   i_load_val in  W-bit load value
//   o_done     out one-cycle expiry pulse
module kp_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == W'(1)) && !i_load;

endmodule

// File: rtl/keypad_code_sender.sv
// keypad_code_sender
// Collects hex digits from a keypad, presents the assembled code word to a
// password lock, interprets the lock's access/alarm reply and enforces a
// retry limit with a timed lockout.
// Optional feature macro: KEYPAD_ENTRY_TIMEOUT_EN -- when defined, a partial
// entry is discarded after ENTRY_TIMEOUT idle cycles between keys.
// Ports:
//   clk, reset                    clock (rising edge), async active-high reset
//   key_valid/key_digit           digit strobe and hex digit
//   key_enter, key_clear          submit / discard strobes
//   access, alarm                 lock reply
//   code, code_valid              code word to the lock, first-cycle pulse
//   busy, granted, denied         status: busy, success pulse, failure pulse
//   locked_out                    high for the whole lockout period
module keypad_code_sender
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int RESP_WAIT      = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 5000,
  parameter int ENTRY_TIMEOUT  = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          key_valid,
  input  logic [DIGIT_W-1:0]            key_digit,
  input  logic                          key_enter,
  input  logic                          key_clear,
  input  logic                          access,
  input  logic                          alarm,
  output logic [DIGIT_W*NUM_DIGITS-1:0] code,
  output logic                          code_valid,
  output logic                          busy,
  output logic                          granted,
  output logic                          denied,
  output logic                          locked_out
);

  localparam int CODE_W  = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  // Response wait and lockout share one timer; size it for the larger load.
  localparam int TMR_MAX = (RESP_WAIT > LOCKOUT_CYCLES) ? RESP_WAIT : LOCKOUT_CYCLES;
  localparam int TMR_W   = timer_width(TMR_MAX);

  localparam logic [CNT_W-1:0] FULL_COUNT   = CNT_W'(NUM_DIGITS);
  localparam logic [TMR_W-1:0] RESP_LOAD    = TMR_W'(RESP_WAIT);
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES);

  state_t             r_state;
  state_t             w_state_next;
  logic [CODE_W-1:0]  r_shreg;
  logic [CNT_W-1:0]   r_count;
  logic [CODE_W-1:0]  r_code;
  logic [TRY_W-1:0]   r_tries;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_tmr_done;
  logic               w_last_try;
  logic               w_ent_done;

  // This failure is the one that exhausts the allowed attempts.
  assign w_last_try = (r_tries >= TRY_W'(MAX_TRIES - 1));

  kp_timer #(.W(TMR_W)) u_main_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  localparam int ENT_W = timer_width(ENTRY_TIMEOUT);
  logic w_ent_load;

  // Every digit seen during capture (not pre-empted by enter/clear) restarts
  // the idle window, including digits dropped because the entry is full.
  assign w_ent_load = ((r_state == ST_IDLE) || (r_state == ST_ENTRY)) &&
                      key_valid && !key_enter && !key_clear;

  kp_timer #(.W(ENT_W)) u_entry_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_ent_load),
    .i_load_val (ENT_W'(ENTRY_TIMEOUT)),
    .o_done     (w_ent_done)
  );
`else
  logic w_unused_entry_timeout;
  assign w_unused_entry_timeout = ^ENTRY_TIMEOUT;
  assign w_ent_done = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    code_valid   = 1'b0;
    busy         = 1'b0;
    granted      = 1'b0;
    denied       = 1'b0;
    locked_out   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (key_clear) begin
          w_state_next = ST_IDLE;
        end else if (!key_enter && key_valid) begin
          w_state_next = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (key_clear) begin
          w_state_next = ST_IDLE;
        end else if (key_enter) begin
          // A short entry never reaches the lock but still costs a try.
          w_state_next = (r_count == FULL_COUNT) ? ST_SEND : ST_DENIED;
        end else if (w_ent_done) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SEND: begin
        code_valid   = 1'b1;
        busy         = 1'b1;
        w_tmr_load   = 1'b1;
        w_tmr_val    = RESP_LOAD;
        w_state_next = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        busy = 1'b1;
        if (alarm) begin
          w_state_next = ST_DENIED;
        end else if (access) begin
          w_state_next = ST_GRANTED;
        end else if (w_tmr_done) begin
          w_state_next = ST_DENIED;
        end
      end
      ST_GRANTED: begin
        granted      = 1'b1;
        w_state_next = ST_IDLE;
      end
      ST_DENIED: begin
        denied = 1'b1;
        if (w_last_try) begin
          w_tmr_load   = 1'b1;
          w_tmr_val    = LOCKOUT_LOAD;
          w_state_next = ST_LOCKOUT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        busy       = 1'b1;
        locked_out = 1'b1;
        if (w_tmr_done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg <= '0;
      r_count <= '0;
      r_code  <= '0;
      r_tries <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ENTRY: begin
          if (key_clear) begin
            r_shreg <= '0;
            r_count <= '0;
          end else if (key_enter) begin
            // Code is latched on the way into SEND so it is on the bus
            // in the same cycle as code_valid.
            if ((r_state == ST_ENTRY) && (r_count == FULL_COUNT)) begin
              r_code <= r_shreg;
            end
          end else if (key_valid) begin
            if (r_count != FULL_COUNT) begin
              r_shreg <= {r_shreg[CODE_W-DIGIT_W-1:0], key_digit};
              r_count <= r_count + 1'b1;
            end
          end else if ((r_state == ST_ENTRY) && w_ent_done) begin
            r_shreg <= '0;
            r_count <= '0;
          end
        end
        ST_GRANTED: begin
          r_tries <= '0;
          r_shreg <= '0;
          r_count <= '0;
          r_code  <= '0;
        end
        ST_DENIED: begin
          r_tries <= r_tries + 1'b1;
          r_shreg <= '0;
          r_count <= '0;
          r_code  <= '0;
        end
        ST_LOCKOUT: begin
          if (w_tmr_done) begin
            r_tries <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign code = r_code;

endmodule

// File: tb/tb_keypad_code_sender.sv
module tb_keypad_code_sender;
  import keypad_pkg::*;

  localparam logic [31:0] PASS = 32'h12345678;
  localparam logic [31:0] BAD  = 32'h1234ABCD;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_enter;
  logic        key_clear;
  logic        access = 1'b0;
  logic        alarm = 1'b0;
  logic [31:0] code;
  logic        code_valid;
  logic        busy;
  logic        granted;
  logic        denied;
  logic        locked_out;

  logic        silent = 1'b0;
  int          compared = 0;
  int          mismatched = 0;
  int          cv_cnt = 0;
  int          dn_cnt = 0;
  int          cv0;
  int          dn0;
  int          n;

  keypad_code_sender dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .key_enter  (key_enter),
    .key_clear  (key_clear),
    .access     (access),
    .alarm      (alarm),
    .code       (code),
    .code_valid (code_valid),
    .busy       (busy),
    .granted    (granted),
    .denied     (denied),
    .locked_out (locked_out)
  );

  always #5 clk = ~clk;

  // Lock model: registers its input, so it replies one cycle after code_valid.
  always @(posedge clk) begin
    access <= !silent && code_valid && (code == PASS);
    alarm  <= !silent && code_valid && (code != PASS);
  end

  always @(negedge clk) begin
    if (code_valid) cv_cnt++;
    if (denied) dn_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter_code(input logic [31:0] c, input int nd);
    for (int i = nd - 1; i >= 0; i--) press(c[4*i +: 4]);
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
    $display("txn: entered %0d digits %h", nd, c);
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_digit = 4'h0; key_enter = 1'b0; key_clear = 1'b0;
    tick();
    tick();
    chk("rst_code", code, 32'h0);
    chk("rst_flags", {27'd0, code_valid, busy, granted, denied, locked_out}, 32'h0);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    reset = 1'b0;
    tick();

    // Correct code, lock grants
    cv0 = cv_cnt;
    enter_code(PASS, 8);
    chk("send_code", code, PASS);
    chk("send_cv", 32'(code_valid), 32'd1);
    chk("send_busy", 32'(busy), 32'd1);
    tick();
    chk("wait_code_held", code, PASS);
    chk("wait_cv_low", 32'(code_valid), 32'd0);
    tick();
    chk("granted_pulse", 32'(granted), 32'd1);
    tick();
    chk("granted_end", 32'(granted), 32'd0);
    chk("idle_code_zero", code, 32'h0);
    chk("idle_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("cv_one_cycle", 32'(cv_cnt - cv0), 32'd1);

    // Wrong code, lock alarms
    enter_code(BAD, 8);
    chk("bad_send_code", code, BAD);
    tick();
    tick();
    chk("bad_denied", 32'(denied), 32'd1);
    tick();
    chk("bad_tries", 32'(dut.r_tries), 32'd1);
    chk("bad_code_clr", code, 32'h0);
    chk("bad_denied_end", 32'(denied), 32'd0);

    // Short entry: denied without touching the lock
    cv0 = cv_cnt;
    enter_code(32'h00000123, 3);
    chk("short_denied", 32'(denied), 32'd1);
    chk("short_busy", 32'(busy), 32'd0);
    tick();
    chk("short_tries", 32'(dut.r_tries), 32'd2);
    chk("short_no_cv", 32'(cv_cnt - cv0), 32'd0);

    // Clear beats a same-cycle digit
    press(4'h1);
    press(4'h2);
    chk("pre_clear_count", 32'(dut.r_count), 32'd2);
    chk("pre_clear_state", 32'(dut.r_state), 32'(ST_ENTRY));
    key_valid = 1'b1; key_digit = 4'h9; key_clear = 1'b1;
    tick();
    key_valid = 1'b0; key_clear = 1'b0;
    chk("clear_count", 32'(dut.r_count), 32'd0);
    chk("clear_state", 32'(dut.r_state), 32'(ST_IDLE));

    // Enter in IDLE is ignored and swallows a same-cycle digit
    key_valid = 1'b1; key_digit = 4'h5; key_enter = 1'b1;
    tick();
    key_valid = 1'b0; key_enter = 1'b0;
    chk("idle_enter_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("idle_enter_count", 32'(dut.r_count), 32'd0);

    // Ninth digit dropped once full; grant resets tries
    for (int d = 1; d <= 9; d++) press(4'(d));
    chk("sat_count", 32'(dut.r_count), 32'd8);
    chk("sat_shreg", dut.r_shreg, PASS);
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
    chk("sat_code", code, PASS);
    tick();
    tick();
    chk("sat_granted", 32'(granted), 32'd1);
    tick();
    chk("grant_clears_tries", 32'(dut.r_tries), 32'd0);

    // Silent lock: denied after RESP_WAIT cycles in WAIT_RESP
    silent = 1'b1;
    enter_code(PASS, 8);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("silent_wait", {30'd0, busy, denied}, 32'd2);
      tick();
    end
    chk("silent_denied", 32'(denied), 32'd1);
    tick();
    chk("silent_tries", 32'(dut.r_tries), 32'd1);
    silent = 1'b0;
    enter_code(PASS, 8);
    tick();
    tick();
    chk("regrant", 32'(granted), 32'd1);
    tick();

    // Three alarms in a row -> lockout
    for (int k = 0; k < 3; k++) begin
      enter_code(BAD, 8);
      tick();
      tick();
      chk("lk_denied", 32'(denied), 32'd1);
      tick();
    end
    chk("lk_locked", 32'(locked_out), 32'd1);
    chk("lk_busy", 32'(busy), 32'd1);
    chk("lk_tries", 32'(dut.r_tries), 32'd3);
    n = 0;
    while (locked_out === 1'b1 && n < 6000) begin
      n++;
      if (n == 10) begin key_valid = 1'b1; key_digit = 4'h7; end
      if (n == 20) key_clear = 1'b1;
      if (n == 30) key_enter = 1'b1;
      tick();
      key_valid = 1'b0; key_clear = 1'b0; key_enter = 1'b0;
    end
    $display("txn: lockout lasted %0d cycles", n);
    chk("lk_cycles", 32'(n), 32'd5000);
    chk("lk_after_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("lk_after_count", 32'(dut.r_count), 32'd0);
    chk("lk_after_tries", 32'(dut.r_tries), 32'd0);
    enter_code(PASS, 8);
    tick();
    tick();
    chk("post_lk_granted", 32'(granted), 32'd1);
    tick();

    // Reset during WAIT_RESP aborts immediately
    silent = 1'b1;
    enter_code(PASS, 8);
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_code", code, 32'h0);
    chk("mid_rst_flags", {27'd0, code_valid, busy, granted, denied, locked_out}, 32'h0);
    tick();
    reset = 1'b0;
    silent = 1'b0;
    tick();

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    dn0 = dn_cnt;
    press(4'h1);
    press(4'h2);
    press(4'h3);
    repeat (999) tick();
    chk("to_still_entry", 32'(dut.r_state), 32'(ST_ENTRY));
    tick();
    chk("to_idle", 32'(dut.r_state), 32'(ST_IDLE));
    chk("to_count", 32'(dut.r_count), 32'd0);
    chk("to_no_denied", 32'(dn_cnt - dn0), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
